microcode_pipeline: RTL

MICROCODE_PIPELINE -- requirements
Module: microcode_pipeline

---
 rtl/microcode_pipeline.sv | 115 +++++++++++
 1 files changed

// File: rtl/microcode_pipeline.sv
// microcode_pipeline -- in-order microcode execution pipeline with per-stage
// stall and flush, bubble insertion behind a stall, and a saturating counter
// of stall cycles seen at the input.
//
// Parameters
//   UCODE_W  microcode word width
//   STAGES   number of pipeline stages holding microcode (2..8)
//   CNT_W    stall-counter width
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid/in_ucode/in_ready   word offered to stage 0 / accepted this cycle
//   stall_req[i]    stage i requests to hold (freezes all earlier stages too)
//   flush[i]        squash the word entering or held in stage i
//   stage_valid     per-stage live bits
//   stage_ucode     stage i word in [i*UCODE_W +: UCODE_W], zero when not live
//   retire          last-stage word leaves the pipeline this cycle
//   stall_cnt       saturating count of cycles with in_ready low
//   stall_cnt_clr   clear stall_cnt (wins over increment)

// One pipeline stage: load / hold / flush of a {valid, ucode} pair.
// Invalid words are stored as zero so a bubble always decodes as a no-op.
module microcode_stage #(
   parameter int UCODE_W = 23
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               hold,
   input  logic               ld_valid,
   input  logic [UCODE_W-1:0] ld_ucode,
   output logic               valid,
   output logic [UCODE_W-1:0] ucode
);
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         valid <= 1'b0;
         ucode <= '0;
      end else if (!hold) begin
         valid <= ld_valid;
         ucode <= ld_valid ? ld_ucode : '0;
      end
   end
endmodule

module microcode_pipeline #(
   parameter int UCODE_W = 23,
   parameter int STAGES  = 4,
   parameter int CNT_W   = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic [UCODE_W-1:0]         in_ucode,
   output logic                       in_ready,
   input  logic [STAGES-1:0]          stall_req,
   input  logic [STAGES-1:0]          flush,
   output logic [STAGES-1:0]          stage_valid,
   output logic [STAGES*UCODE_W-1:0]  stage_ucode,
   output logic                       retire,
   output logic [CNT_W-1:0]           stall_cnt,
   input  logic                       stall_cnt_clr
);
   logic [STAGES-1:0]              hold;
   logic [STAGES-1:0]              vld_pipe;
   logic [STAGES-1:0][UCODE_W-1:0] ucode_q;
   logic [STAGES-1:0]              ld_valid;
   logic [STAGES-1:0][UCODE_W-1:0] ld_ucode;
   logic [STAGES-1:0][UCODE_W-1:0] ucode_out;

   // A stall anywhere downstream freezes every stage in front of it.
   always_comb begin
      hold = '0;
      hold[STAGES-1] = stall_req[STAGES-1];
      for (int i = STAGES-2; i >= 0; i--)
         hold[i] = stall_req[i] | hold[i+1];
   end

   assign in_ready = !hold[0];

   for (genvar g = 0; g < STAGES; g++) begin : g_stage
      if (g == 0) begin : g_head
         assign ld_valid[g] = in_valid;
         assign ld_ucode[g] = in_ucode;
      end else begin : g_body
         // If the feeding stage holds while this one moves, take a bubble so
         // the held word is not duplicated downstream.
         assign ld_valid[g] = vld_pipe[g-1] & ~hold[g-1];
         assign ld_ucode[g] = ucode_q[g-1];
      end

      microcode_stage #(.UCODE_W(UCODE_W)) u_stage (
         .clk      (clk),
         .rst      (rst),
         .flush    (flush[g]),
         .hold     (hold[g]),
         .ld_valid (ld_valid[g]),
         .ld_ucode (ld_ucode[g]),
         .valid    (vld_pipe[g]),
         .ucode    (ucode_q[g])
      );

      assign ucode_out[g] = vld_pipe[g] ? ucode_q[g] : '0;
   end

   assign stage_valid = vld_pipe;
   assign stage_ucode = ucode_out;
   assign retire      = vld_pipe[STAGES-1] & ~stall_req[STAGES-1] & ~flush[STAGES-1];

   always_ff @(posedge clk) begin
      if (rst || stall_cnt_clr)
         stall_cnt <= '0;
      else if (!in_ready && stall_cnt != {CNT_W{1'b1}})
         stall_cnt <= stall_cnt + 1'b1;
   end
endmodule
